// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared states and default sizes for the tri-state bus arbiter
package bus_arb_pkg;
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    localparam int N_REQ_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int BUS_W        = 16;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting just above the last owner
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_owner,
    output logic [$clog2(N_REQ)-1:0] win,
    output logic                     valid
);
    localparam int OW = $clog2(N_REQ);

    // scan from the farthest candidate down to last_owner+1 so the nearest requester wins
    always_comb begin
        logic [OW-1:0] j;
        j     = '0;
        win   = '0;
        valid = |req;
        for (int i = N_REQ; i >= 1; i--) begin
            j = OW'((int'(last_owner) + i) % N_REQ);
            if (req[j]) win = j;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner of a shared tri-state bus with hold limit and dead turnaround cycle
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                     clk,
    input  logic                     rstIn,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_busy,
    output logic                     preempt
);
    localparam int OW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD);

    state_t         state, state_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [OW-1:0]  last_owner, last_n, owner_n, win;
    logic [N_REQ-1:0] gnt_n;
    logic           preempt_n, valid, others, limit, drop;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .win        (win),
        .valid      (valid)
    );

    // drivers share one register so they can never disagree
    assign drv_en = gnt;

    // next-state: OWN keeps or gives up the bus, IDLE and TURN both arbitrate
    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner;
        last_n    = last_owner;
        hold_n    = hold_cnt;
        preempt_n = 1'b0;
        others    = |(req & ~gnt);
        limit     = hold_cnt == HW'(MAX_HOLD - 1);
        drop      = !req[owner] || (limit && others);
        if (state == OWN) begin
            if (drop) begin
                state_n   = TURN;
                gnt_n     = '0;
                owner_n   = '0;
                hold_n    = '0;
                preempt_n = req[owner];
            end else begin
                hold_n = limit ? hold_cnt : hold_cnt + HW'(1);
            end
        end else if (valid) begin
            state_n = OWN;
            gnt_n   = N_REQ'(1) << win;
            owner_n = win;
            last_n  = win;
            hold_n  = '0;
        end else begin
            state_n = IDLE;
            gnt_n   = '0;
            owner_n = '0;
        end
    end

    // state and registered outputs; reset parks last_owner at the top so requester 0 wins first
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= OW'(N_REQ - 1);
            hold_cnt   <= '0;
            bus_busy   <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            owner      <= owner_n;
            last_owner <= last_n;
            hold_cnt   <= hold_n;
            bus_busy   <= |gnt_n;
            preempt    <= preempt_n;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed grants for bus_arbiter
module tb_bus_arbiter;
    logic       clk = 1'b0;
    logic       rstIn = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt, drv_en;
    logic [1:0] owner;
    logic       bus_busy, preempt;
    int         errors = 0;
    int         checks = 0;
    logic       mon_on = 1'b0;

    bus_arbiter #(.N_REQ(4), .MAX_HOLD(8)) dut (
        .clk      (clk),
        .rstIn    (rstIn),
        .req      (req),
        .gnt      (gnt),
        .drv_en   (drv_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_own(input string tag, input logic [3:0] g, input logic [1:0] o, input logic p);
        check({tag, "_gnt"}, gnt, g);
        check({tag, "_drv"}, drv_en, g);
        check({tag, "_own"}, owner, o);
        check({tag, "_busy"}, bus_busy, |g);
        check({tag, "_pre"}, preempt, p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstIn = 1'b0;
        req   = '0;
        @(negedge clk);
        rstIn = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("contention_eq", drv_en, gnt);
            check("contention_1hot", $onehot0(gnt), 1);
        end
    end

    initial begin
        #1;
        expect_own("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rstIn  = 1'b1;
        mon_on = 1'b1;
        req    = 4'b0001;
        @(negedge clk);
        expect_own("single_grant", 4'b0001, 2'd0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        expect_own("single_turn", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        expect_own("single_idle", 4'b0000, 2'd0, 1'b0);

        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 8; i++) begin @(negedge clk); expect_own("hold_o0", 4'b0001, 2'd0, 1'b0); end
        @(negedge clk);
        expect_own("preempt0", 4'b0000, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin @(negedge clk); expect_own("hold_o2", 4'b0100, 2'd2, 1'b0); end
        @(negedge clk);
        expect_own("preempt2", 4'b0000, 2'd0, 1'b1);
        @(negedge clk);
        expect_own("back_o0", 4'b0001, 2'd0, 1'b0);

        do_reset();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin @(negedge clk); expect_own("solo3", 4'b1000, 2'd3, 1'b0); end

        do_reset();
        req = 4'b0010;
        @(negedge clk);
        expect_own("blip_grant", 4'b0010, 2'd1, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        expect_own("blip_turn", 4'b0000, 2'd0, 1'b0);

        do_reset();
        req = 4'b0010;
        @(negedge clk);
        expect_own("o1_grant", 4'b0010, 2'd1, 1'b0);
        req = 4'b1100;
        @(negedge clk);
        expect_own("o1_turn", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        expect_own("o2_after", 4'b0100, 2'd2, 1'b0);
        @(negedge clk);
        expect_own("o2_hold", 4'b0100, 2'd2, 1'b0);

        #2;
        rstIn = 1'b0;
        #1;
        expect_own("async_rst", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        rstIn = 1'b1;
        req   = 4'b1111;
        @(negedge clk);
        expect_own("post_rst", 4'b0001, 2'd0, 1'b0);
        req = 4'b1110;
        @(negedge clk);
        expect_own("post_rst_turn", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        expect_own("post_rst_next", 4'b0010, 2'd1, 1'b0);

        mon_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the 16-bit tri-state data bus.
REQ-002 Parameter MAX_HOLD, default 8: cycles an owner keeps the bus before preemption when others wait.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rstIn  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester bus request, level-sensitive, held while the bus is wanted.
REQ-006 gnt  output  N_REQ  one-hot-or-zero grant to the current owner.
REQ-007 drv_en  output  N_REQ  one-hot-or-zero enable for each requester's 16-bit tri-state buffer.
REQ-008 owner  output  2  index of the current owner; 0 when no owner.
REQ-009 bus_busy  output  1  high while any gnt bit is high.
REQ-010 preempt  output  1  one-cycle pulse when an owner loses the bus to the MAX_HOLD limit.

Function
REQ-011 States: IDLE (no owner), OWN (one owner drives), TURN (one dead cycle, all drv_en low, bus floats to all-Z).
REQ-012 All outputs are registered; gnt and drv_en are always equal, never more than one bit set.
REQ-013 IDLE: when any req bit is sampled high at edge k, go to OWN; the winner's gnt/drv_en are high in cycle k+1.
REQ-014 Winner selection is round-robin: the first requester with req high, searching upward from last_owner+1 modulo N_REQ.
REQ-015 last_owner is updated to the winner at every grant.
REQ-016 OWN: hold_cnt resets to 0 on grant and increments each cycle, saturating at MAX_HOLD-1.
REQ-017 OWN exits to TURN when the owner's req is sampled low (voluntary release).
REQ-018 OWN exits to TURN when hold_cnt equals MAX_HOLD-1 and any other req bit is high; preempt pulses in the first TURN cycle.
REQ-019 Owner at the MAX_HOLD-1 limit with no other requester keeps the bus indefinitely; no preempt.
REQ-020 TURN lasts exactly one cycle, with gnt=0, drv_en=0, bus_busy=0 and owner=0.
REQ-021 TURN arbitrates like IDLE: any req high goes straight to OWN of the round-robin winner, otherwise to IDLE.
REQ-022 Ownership changes therefore always have exactly one undriven cycle between two drivers.
REQ-023 If a preempted owner still requests, it takes part in the next arbitration at lowest priority.
REQ-024 Request-and-release in the same cycle as a grant: the owner holds the bus for at least one cycle, then REQ-017 applies.
REQ-025 req bits outside the N_REQ range, or X/Z on req, are not supported.

Reset
REQ-026 Asserting rstIn low immediately clears gnt, drv_en, owner, bus_busy, preempt, hold_cnt to 0 and sets state to IDLE, even mid-ownership.
REQ-027 Reset sets last_owner to N_REQ-1, so requester 0 has top priority on the first arbitration.
REQ-028 The first arbitration may take place on the first rising edge after rstIn goes high.

Structure
REQ-029 Shared package bus_arb_pkg holds the state enum (IDLE, OWN, TURN), the default N_REQ and MAX_HOLD, and the bus width constant 16.
REQ-030 A combinational sub-module rr_pick takes req and last_owner and returns a winner index and a valid flag.
REQ-031 The existing triStateBuffer instances stay outside this block and are driven by drv_en.

Verification
REQ-032 Reset release, req=4'b0001 → gnt=4'b0001, owner=0 one cycle later; req cleared → TURN cycle, then gnt=0.
REQ-033 req=4'b0101 held, MAX_HOLD=8 → owner 0 for 8 cycles, preempt pulse with one TURN cycle, owner 2 for 8 cycles, then owner 0 again.
REQ-034 Only req[3] held for 20 cycles → gnt=4'b1000 throughout, preempt never asserted.
REQ-035 Owner 1 releases while req=4'b1100 → exactly one cycle with drv_en=0, then gnt=4'b0100.
REQ-036 rstIn pulled low mid-OWN → gnt and drv_en are 0 in the same cycle with no clock edge; after release, req=4'b1111 grants requester 0 first.
REQ-037 Every cycle: check drv_en has at most one bit set and equals gnt (bus contention assertion).
